// File: rtl/prbs_checker.sv
// prbs_checker: checks a received word stream against the lfsr recurrence
//   nxt(x) = ((x ^ ({WIDTH{x[WIDTH-1]}} & POLY)) << 1) | !x[WIDTH-1]
// It self-synchronises (HUNT -> SYNC -> LOCKED), then runs a flywheel
// predictor so a corrupt word costs exactly one error. Mismatches while
// LOCKED are flagged and counted.
//
// Ports
//   clk        in   1      clock, posedge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data qualifier
//   in_data    in   WIDTH  received word
//   clear      in   1      synchronous clear of err_cnt / word_cnt
//   locked     out  1      checker is in LOCKED
//   err_pulse  out  1      one-cycle flag: last checked word mismatched
//   err_cnt    out  ERR_W  saturating count of mismatched words while LOCKED
//   word_cnt   out  32     saturating count of words checked while LOCKED
//   state      out  2      00 HUNT, 01 SYNC, 10 LOCKED
module prbs_checker #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     POLY     = WIDTH'(32'h800007c3),
  parameter int unsigned          LOCK_CNT = 4,
  parameter int unsigned          LOSS_CNT = 3,
  parameter int unsigned          ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt,
  output logic [1:0]       state
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);
  localparam int unsigned WCNT_W  = 32;

  // Elaboration-time parameter sanity
  if (WIDTH < 2) begin : g_chk_width
    $error("prbs_checker: WIDTH must be at least 2");
  end
  if (LOCK_CNT < 1) begin : g_chk_lock
    $error("prbs_checker: LOCK_CNT must be at least 1");
  end
  if (LOSS_CNT < 1) begin : g_chk_loss
    $error("prbs_checker: LOSS_CNT must be at least 1");
  end
  if (ERR_W < 1) begin : g_chk_errw
    $error("prbs_checker: ERR_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic [WIDTH-1:0]   pred;
  logic [WIDTH-1:0]   pred_d;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_d;
  logic [MISS_W-1:0]  miss;
  logic [MISS_W-1:0]  miss_d;
  logic               locked_d;
  logic               err_pulse_d;
  logic [ERR_W-1:0]   err_cnt_d;
  logic [WCNT_W-1:0]  word_cnt_d;
  logic               err_inc;
  logic               word_inc;

  logic               hit;
  logic               match_done;
  logic               loss_done;

  // One step of the generator recurrence (shift drops the old MSB)
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] t;
    t = x ^ ({WIDTH{x[WIDTH-1]}} & POLY);
    return (t << 1) | {{(WIDTH-1){1'b0}}, ~x[WIDTH-1]};
  endfunction

  // Shared comparison terms used by both next-state and output logic
  assign hit        = (in_data == pred);
  assign match_done = ((32'(match) + 32'd1) == LOCK_CNT);
  assign loss_done  = ((32'(miss) + 32'd1) == LOSS_CNT);

  assign state = cur_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_HUNT;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; idle cycles hold the state
  always_comb begin
    nxt_state = cur_state;
    if (in_valid) begin
      case (cur_state)
        ST_HUNT: begin
          nxt_state = ST_SYNC;
        end
        ST_SYNC: begin
          if (hit && match_done) begin
            nxt_state = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!hit && loss_done) begin
            nxt_state = ST_HUNT;
          end
        end
        default: begin
          nxt_state = ST_HUNT;
        end
      endcase
    end
  end

  // Output / datapath next values; registered below
  always_comb begin
    pred_d      = pred;
    match_d     = match;
    miss_d      = miss;
    locked_d    = locked;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    word_inc    = 1'b0;

    if (in_valid) begin
      case (cur_state)
        ST_HUNT: begin
          pred_d  = nxt(in_data);
          match_d = '0;
        end
        ST_SYNC: begin
          // Still acquiring: reseed from the received word every time
          pred_d = nxt(in_data);
          if (hit) begin
            match_d = match + MATCH_W'(1);
            if (match_done) begin
              miss_d   = '0;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction never follows in_data once locked
          pred_d   = nxt(pred);
          word_inc = 1'b1;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss + MISS_W'(1);
            if (loss_done) begin
              locked_d = 1'b0;
            end
          end
        end
        default: begin
          match_d  = '0;
          miss_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    // Saturating counters; clear takes priority over an increment
    err_cnt_d  = err_cnt;
    word_cnt_d = word_cnt;
    if (err_inc && !(&err_cnt)) begin
      err_cnt_d = err_cnt + ERR_W'(1);
    end
    if (word_inc && !(&word_cnt)) begin
      word_cnt_d = word_cnt + WCNT_W'(1);
    end
    if (clear) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred      <= '0;
      match     <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      pred      <= pred_d;
      match     <= match_d;
      miss      <= miss_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_cnt   <= err_cnt_d;
      word_cnt  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker (WIDTH=8, POLY=8'hc3,
// LOCK_CNT=4, LOSS_CNT=3, ERR_W=4).
// Reference sequence from 00: 00,01,03,07,0f,1f,3f,7f,ff,78,f1,64,c9,14,29
module tb_prbs_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ERR_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [31:0]      word_cnt;
  logic [1:0]       state;

  int n_cmp;
  int n_bad;

  prbs_checker #(
    .WIDTH    (WIDTH),
    .POLY     (8'hc3),
    .LOCK_CNT (4),
    .LOSS_CNT (3),
    .ERR_W    (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream generator used only to produce long stimulus runs
  function automatic logic [7:0] gen_nxt(input logic [7:0] x);
    logic [7:0] t;
    t = x ^ ({8{x[7]}} & 8'hc3);
    return (t << 1) | {7'd0, ~x[7]};
  endfunction

  // Present one cycle of inputs; return 1 time unit after the clock edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Lock onto the sequence starting at 00 (next expected word is 1f)
  task automatic lock_from_zero();
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h07, 1'b0);
    cyc(1'b1, 8'h0f, 1'b0);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    clear    = 1'b0;
    #3;
    n_cmp++;
    if ({locked, err_pulse, state} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got locked=%0b pulse=%0b state=%b, want 0/0/00", locked, err_pulse, state);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({err_cnt, word_cnt} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_counts: got err=%0d words=%0d, want 0/0", err_cnt, word_cnt);
    end
    do_reset();
  endtask

  task automatic test_acquire();
    do_reset();
    cyc(1'b1, 8'h00, 1'b0);
    n_cmp++;
    if (state !== 2'b01 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL acq_sync: got state=%b locked=%0b, want 01/0", state, locked);
    end
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h07, 1'b0);
    n_cmp++;
    if (state !== 2'b01 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL acq_not_yet: got state=%b locked=%0b, want 01/0", state, locked);
    end
    cyc(1'b1, 8'h0f, 1'b0);
    n_cmp++;
    if (state !== 2'b10 || locked !== 1'b1 || err_cnt !== 4'd0 || word_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL acq_locked: got state=%b locked=%0b err=%0d words=%0d, want 10/1/0/0",
               state, locked, err_cnt, word_cnt);
    end
  endtask

  // Continues from the locked state left by test_acquire
  task automatic test_single_error();
    cyc(1'b1, 8'h1f, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b0 || word_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL single_good: got pulse=%0b words=%0d, want 0/1", err_pulse, word_cnt);
    end
    cyc(1'b1, 8'h3e, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b1 || err_cnt !== 4'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_bad: got pulse=%0b err=%0d locked=%0b, want 1/1/1", err_pulse, err_cnt, locked);
    end
    cyc(1'b1, 8'h7f, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b0 || err_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL single_recover: got pulse=%0b err=%0d, want 0/1", err_pulse, err_cnt);
    end
    cyc(1'b1, 8'hff, 1'b0);
    n_cmp++;
    if (err_cnt !== 4'd1 || word_cnt !== 32'd4 || locked !== 1'b1 || state !== 2'b10) begin
      n_bad++;
      $display("FAIL single_end: got err=%0d words=%0d locked=%0b state=%b, want 1/4/1/10",
               err_cnt, word_cnt, locked, state);
    end
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] r;
    do_reset();
    lock_from_zero();
    r = 8'h1f;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, r ^ 8'h80, 1'b0);
      r = gen_nxt(r);
      if (i == 1) begin
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 4'd2) begin
          n_bad++;
          $display("FAIL loss_two_bad: got locked=%0b err=%0d, want 1/2", locked, err_cnt);
        end
      end
    end
    n_cmp++;
    if (locked !== 1'b0 || state !== 2'b00 || err_cnt !== 4'd3 || word_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL loss_third_bad: got locked=%0b state=%b err=%0d words=%0d, want 0/00/3/3",
               locked, state, err_cnt, word_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] r;
    do_reset();
    lock_from_zero();
    r = 8'h1f;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, r ^ 8'h01, 1'b0);
      r = gen_nxt(r);
      if (i == 19) begin
        n_cmp++;
        if (err_pulse !== 1'b1 || err_cnt !== 4'hf) begin
          n_bad++;
          $display("FAIL sat_last_bad: got pulse=%0b err=%0d, want 1/15", err_pulse, err_cnt);
        end
      end
      cyc(1'b1, r, 1'b0);
      r = gen_nxt(r);
      if (i == 0) begin
        n_cmp++;
        if (err_cnt !== 4'd1 || word_cnt !== 32'd2) begin
          n_bad++;
          $display("FAIL sat_first_pair: got err=%0d words=%0d, want 1/2", err_cnt, word_cnt);
        end
      end
    end
    n_cmp++;
    if (err_cnt !== 4'hf || word_cnt !== 32'd40 || locked !== 1'b1 || state !== 2'b10) begin
      n_bad++;
      $display("FAIL sat_end: got err=%0d words=%0d locked=%0b state=%b, want 15/40/1/10",
               err_cnt, word_cnt, locked, state);
    end
  endtask

  task automatic test_clear();
    do_reset();
    lock_from_zero();
    cyc(1'b1, 8'h1e, 1'b0);
    n_cmp++;
    if (err_cnt !== 4'd1 || err_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_pre: got err=%0d pulse=%0b, want 1/1", err_cnt, err_pulse);
    end
    cyc(1'b1, 8'h3e, 1'b1);
    n_cmp++;
    if (err_cnt !== 4'd0 || word_cnt !== 32'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_with_bad: got err=%0d words=%0d pulse=%0b locked=%0b, want 0/0/1/1",
               err_cnt, word_cnt, err_pulse, locked);
    end
    cyc(1'b1, 8'h7f, 1'b0);
    n_cmp++;
    if (err_cnt !== 4'd0 || word_cnt !== 32'd1 || err_pulse !== 1'b0 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_after: got err=%0d words=%0d pulse=%0b locked=%0b, want 0/1/0/1",
               err_cnt, word_cnt, err_pulse, locked);
    end
  endtask

  task automatic test_gaps_and_reset();
    do_reset();
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'hAA, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h5A, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h07, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (state !== 2'b01 || locked !== 1'b0 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_sync_hold: got state=%b locked=%0b pulse=%0b, want 01/0/0", state, locked, err_pulse);
    end
    cyc(1'b1, 8'h0f, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (state !== 2'b10 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_locked: got state=%b locked=%0b, want 10/1", state, locked);
    end
    cyc(1'b1, 8'h1f, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h3f, 1'b0);
    cyc(1'b1, 8'h7f, 1'b0);
    n_cmp++;
    if (err_cnt !== 4'd0 || word_cnt !== 32'd3 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_no_err: got err=%0d words=%0d pulse=%0b, want 0/3/0", err_cnt, word_cnt, err_pulse);
    end
    cyc(1'b1, 8'hfe, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b0 || err_cnt !== 4'd1 || word_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL gap_pulse_drop: got pulse=%0b err=%0d words=%0d, want 0/1/4", err_pulse, err_cnt, word_cnt);
    end

    // Asynchronous reset between clock edges while locked
    in_valid = 1'b1;
    in_data  = 8'h78;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({locked, err_pulse, err_cnt, word_cnt, state} !== 40'd0) begin
      n_bad++;
      $display("FAIL async_reset: got locked=%0b pulse=%0b err=%0d words=%0d state=%b, want all 0",
               locked, err_pulse, err_cnt, word_cnt, state);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b1, 8'h78, 1'b0);
    cyc(1'b1, 8'hf1, 1'b0);
    cyc(1'b1, 8'h64, 1'b0);
    cyc(1'b1, 8'hc9, 1'b0);
    n_cmp++;
    if (state !== 2'b01 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL reacq_sync: got state=%b locked=%0b, want 01/0", state, locked);
    end
    cyc(1'b1, 8'h14, 1'b0);
    n_cmp++;
    if (state !== 2'b10 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL reacq_locked: got state=%b locked=%0b, want 10/1", state, locked);
    end
    cyc(1'b1, 8'h29, 1'b0);
    n_cmp++;
    if (err_cnt !== 4'd0 || word_cnt !== 32'd1 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL reacq_good: got err=%0d words=%0d pulse=%0b, want 0/1/0", err_cnt, word_cnt, err_pulse);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;

    test_reset();
    test_acquire();
    test_single_error();
    test_loss_of_lock();
    test_saturate();
    test_clear();
    test_gaps_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
